// File: rtl/de1_soc_alternative_hps_master_rsp_timing_adt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : de1_soc_alternative_hps_master_rsp_timing_adt                 |
// | Purpose  : Response-path Avalon-ST timing adapter for the HPS master     |
// |            bridge. The upstream side is a readyLatency=1 source and the  |
// |            downstream side is a readyLatency=0 sink. A small skid FIFO   |
// |            absorbs the beat already in flight when in_ready drops, so    |
// |            downstream backpressure never loses data. A sticky flag       |
// |            records any beat that arrives without permission.             |
// | Ports    : clk, reset (async, active-high)                                |
// |            in_valid/in_data/in_ready   upstream, in_ready is registered   |
// |            out_valid/out_data/out_ready downstream, first-word-fall-thru |
// |            overflow  sticky protocol-violation flag (cleared by reset)   |
// |            level     current FIFO occupancy                              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module de1_soc_alternative_hps_master_rsp_timing_adt #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH      = (AW+1)'(DEPTH);
  // Highest occupancy at which a further beat may still be invited: the
  // invited beat plus the one possibly already in flight must both fit.
  localparam logic [AW:0] C_HIGH_WATER = (AW+1)'(DEPTH - 2);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_in_ready;
  logic              r_ready_q;
  logic              r_overflow;

  logic [AW:0]       w_count_next;
  logic              w_full;
  logic              w_write_en;
  logic              w_read_en;
  logic              w_illegal;
  logic              w_out_valid;

  assign w_full      = (r_count == C_DEPTH);
  assign w_out_valid = (r_count != '0);

  // r_ready_q is in_ready as seen by the source one cycle ago, i.e. the
  // permission that applies to the beat presented this cycle.
  assign w_write_en  = in_valid & r_ready_q & ~w_full;
  assign w_illegal   = in_valid & (~r_ready_q | w_full);
  assign w_read_en   = w_out_valid & out_ready;

  assign w_count_next = r_count
                      + {{AW{1'b0}}, w_write_en}
                      - {{AW{1'b0}}, w_read_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_in_ready <= 1'b0;
      r_ready_q  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_write_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_read_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // No credit is taken for a read this cycle beyond what count_next
      // already reflects; the source sees this a cycle late.
      r_in_ready <= (w_count_next <= C_HIGH_WATER);
      r_ready_q  <= r_in_ready;
      if (w_illegal) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_write_en) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign overflow  = r_overflow;
  assign level     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_de1_soc_alternative_hps_master_rsp_timing_adt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_de1_soc_alternative_hps_master_rsp_timing_adt              |
// | Purpose  : Directed and randomised self-checking bench for the HPS       |
// |            response timing adapter (DATA_W=8, DEPTH=4).                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_de1_soc_alternative_hps_master_rsp_timing_adt;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              overflow;
  logic [2:0]        level;

  de1_soc_alternative_hps_master_rsp_timing_adt #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  // Reference model state
  logic [DATA_W-1:0] m_q[$];
  logic              m_rdy = 1'b0;  // expected in_ready
  logic              m_rq  = 1'b0;  // expected in_ready delayed one cycle
  logic              m_ovf = 1'b0;
  logic              legal = 1'b0;  // source may present a beat this cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rdy = 1'b0;
    m_rq  = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Advance one clock: predict from the currently driven inputs, step the
  // DUT, then compare every output against the model.
  task automatic tick();
    logic before_rdy;
    logic full;
    logic wr;
    logic ill;
    logic rd;
    logic [DATA_W-1:0] head;
    before_rdy = in_ready;
    if (reset) begin
      model_reset();
    end else begin
      full = (m_q.size() == DEPTH);
      wr   = in_valid && m_rq && !full;
      ill  = in_valid && (!m_rq || full);
      rd   = (m_q.size() != 0) && out_ready;
      if (rd) void'(m_q.pop_front());
      if (wr) begin
        m_q.push_back(in_data);
        n_acc++;
      end
      if (ill) m_ovf = 1'b1;
      m_rq  = m_rdy;
      m_rdy = (m_q.size() <= DEPTH - 2);
    end
    @(posedge clk);
    #1;
    legal = before_rdy;
    head  = (m_q.size() != 0) ? m_q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("out_data",  32'(out_data),  32'(head));
    chk("level",     32'(level),     32'(m_q.size()));
    chk("in_ready",  32'(in_ready),  32'(m_rdy));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("full_and_ready", 32'(level == 3'(DEPTH) && in_ready), 32'(0));
  endtask

  // Present one beat as soon as the readyLatency=1 rule allows it.
  task automatic send(input logic [DATA_W-1:0] d);
    int g;
    in_valid = 1'b0;
    g = 0;
    while (!legal && g < 20) begin
      tick();
      g++;
    end
    if (!legal) chk("send_timeout", 32'(legal), 32'(1));
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int g;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));

    // 1: back-to-back stream with out_ready held high
    reset = 1'b0;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'(1));
    tick();
    k = 0;
    g = 0;
    while (k < 16 && g < 100) begin
      logic sent;
      sent     = legal;
      in_valid = sent;
      in_data  = 8'(k);
      tick();
      if (sent) begin
        chk("t1_latency", 32'(out_data), 32'(k));
        chk("t1_level_le1", 32'(level <= 3'd1), 32'(1));
        k++;
      end
      g++;
    end
    chk("t1_done", 32'(k), 32'(16));
    in_valid = 1'b0;
    tick();
    tick();

    // 2: stall downstream, fill until in_ready drops
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("t2_level3", 32'(level), 32'(3));
    chk("t2_ready_low", 32'(in_ready), 32'(0));
    tick();
    chk("t2_hold_level", 32'(level), 32'(3));

    // 3: beat without permission is dropped and flagged
    in_valid = 1'b1;
    in_data  = 8'hAA;
    tick();
    in_valid = 1'b0;
    chk("t3_overflow", 32'(overflow), 32'(1));
    chk("t3_level", 32'(level), 32'(3));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_drain", 32'(out_data), 32'(8'h20 + i));
      tick();
    end
    chk("t2_empty", 32'(level), 32'(0));
    send(8'h40);
    chk("t3_pass0", 32'(out_data), 32'(8'h40));
    send(8'h41);
    chk("t3_pass1", 32'(out_data), 32'(8'h41));
    chk("t3_sticky", 32'(overflow), 32'(1));
    tick();

    // 4: simultaneous read and write at level 2 across pointer wrap
    out_ready = 1'b0;
    send(8'h30);
    send(8'h31);
    chk("t4_level2", 32'(level), 32'(2));
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) begin
      send(8'(8'h30 + i));
      chk("t4_level_hold", 32'(level), 32'(2));
      chk("t4_head", 32'(out_data), 32'(8'h30 + i - 1));
    end
    in_valid = 1'b0;
    chk("t4_tail0", 32'(out_data), 32'(8'h38));
    tick();
    chk("t4_tail1", 32'(out_data), 32'(8'h39));
    tick();
    chk("t4_empty", 32'(level), 32'(0));

    // 5: reset mid-stream discards buffered beats
    out_ready = 1'b0;
    send(8'h50);
    send(8'h51);
    send(8'h52);
    chk("t5_level3", 32'(level), 32'(3));
    reset = 1'b1;
    #2;
    model_reset();
    chk("t5_async_valid", 32'(out_valid), 32'(0));
    chk("t5_async_level", 32'(level), 32'(0));
    chk("t5_async_ready", 32'(in_ready), 32'(0));
    chk("t5_async_ovf", 32'(overflow), 32'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("t5_ready_up", 32'(in_ready), 32'(1));
    chk("t5_no_stale", 32'(out_valid), 32'(0));
    tick();
    chk("t5_legal", 32'(legal), 32'(1));
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_new_valid", 32'(out_valid), 32'(1));
    chk("t5_new_data", 32'(out_data), 32'(8'h55));
    tick();

    // 6: random compliant source and random backpressure
    n_acc = 0;
    g = 0;
    while (n_acc < 2000 && g < 30000) begin
      in_valid  = legal && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
      chk("t6_level_max", 32'(level <= 3'(DEPTH)), 32'(1));
      g++;
    end
    chk("t6_beats", 32'(n_acc >= 2000), 32'(1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t6_drained", 32'(level), 32'(0));
    chk("t6_no_ovf", 32'(overflow), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
